// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles a framed big-endian byte stream into
// words, writes them to sequential addresses and releases the core once the checksum matches.
module imem_loader #(
  parameter logic [31:0] ADDR_BASE = 32'd0,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_write_en,
  output logic [31:0] imem_write_addr,
  output logic [31:0] imem_write_data,
  output logic        cpu_rst_n,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_DATA  = 3'd1,
    S_CSUM  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] count_q, count_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] sum_q, sum_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;

  logic        accept_s;
  logic [31:0] word_s;

  assign accept_s = byte_valid & ready_q;
  // The three bytes already held plus the incoming one form the complete big-endian word.
  assign word_s   = {shift_q, byte_data};

  // Next-state, word assembly and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    count_d     = count_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ready_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cpu_rst_n_d = 1'b0;

    if (accept_s) begin
      shift_d = word_s[23:0];
      cnt_d   = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        case (state_q)
          S_HDR: begin
            count_d = word_s;
            idx_d   = 32'd0;
            if (word_s > MAX_W) begin
              state_d = S_ERROR;
            end else if (word_s == 32'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end
          S_DATA: begin
            we_d    = 1'b1;
            addr_d  = ADDR_BASE + {idx_q[29:0], 2'b00};
            wdata_d = word_s;
            sum_d   = sum_q + word_s;
            idx_d   = idx_q + 32'd1;
            if ((idx_q + 32'd1) == count_q) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end
          S_CSUM: begin
            if (word_s == sum_q) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ERROR;
            end
          end
          default: state_d = state_q;
        endcase
      end else begin
        state_d = state_q;
      end
    end else begin
      shift_d = shift_q;
    end

    case (state_d)
      S_HDR, S_DATA, S_CSUM: ready_d = 1'b1;
      default:               ready_d = 1'b0;
    endcase

    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERROR);
    cpu_rst_n_d = (state_d == S_DONE);
  end

  // State and output registers; everything clears asynchronously on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      cnt_q       <= 2'd0;
      shift_q     <= 24'd0;
      count_q     <= 32'd0;
      idx_q       <= 32'd0;
      sum_q       <= 32'd0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign byte_ready      = ready_q;
  assign imem_write_en   = we_q;
  assign imem_write_addr = addr_q;
  assign imem_write_data = wdata_q;
  assign cpu_rst_n       = cpu_rst_n_q;
  assign load_done       = done_q;
  assign load_error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a per-cycle vector table for the nominal frame,
// then directed sequences for zero-length, bad checksum, oversize, gaps and mid-load reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        imem_write_en;
  logic [31:0] imem_write_addr;
  logic [31:0] imem_write_data;
  logic        cpu_rst_n;
  logic        load_done;
  logic        load_error;

  int total = 0;
  int bad = 0;

  logic [31:0] wa [0:63];
  logic [31:0] wd [0:63];
  int          nw = 0;
  int          wbase = 0;

  imem_loader #(.ADDR_BASE(32'd0), .MAX_WORDS(256)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .imem_write_en   (imem_write_en),
    .imem_write_addr (imem_write_addr),
    .imem_write_data (imem_write_data),
    .cpu_rst_n       (cpu_rst_n),
    .load_done       (load_done),
    .load_error      (load_error)
  );

  always #5 clk = ~clk;

  // Record every write strobe cycle; a stuck strobe shows up as extra entries.
  always @(negedge clk) begin
    if (rst_n && imem_write_en && nw < 64) begin
      wa[nw] = imem_write_addr;
      wd[nw] = imem_write_data;
      nw = nw + 1;
    end
  end

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        err;
    logic        cpu;
  } vec_t;

  vec_t tbl [0:17];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rdy, input logic we,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic done, input logic err, input logic cpu);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.addr = addr; r.data = data;
    r.done = done; r.err = err; r.cpu = cpu;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {59'd0, byte_ready, imem_write_en, imem_write_addr, imem_write_data,
            load_done, load_error, cpu_rst_n};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    wbase = nw;
    rst_n = 1'b1;
  endtask

  // Present one byte and hold it until it transfers; ends at the negedge after the transfer.
  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data = d;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL send_timeout: byte_ready never rose for byte %0h", d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      byte_valid = 1'b0;
      byte_data = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    logic [31:0] t;
    t = w;
    for (int b = 0; b < 4; b++) begin
      if (gaps) idle(int'($urandom_range(3, 0)));
      send(t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic send_nominal(input bit gaps, input logic [31:0] csum);
    send_word(32'h0000_0002, gaps);
    send_word(32'h2408_0005, gaps);
    send_word(32'h0000_0008, gaps);
    send_word(csum, gaps);
    byte_valid = 1'b0;
  endtask

  task automatic chk_nominal_writes(input string tag);
    chk({tag, "_nwrites"}, 128'(nw - wbase), 128'd2);
    if (nw - wbase == 2) begin
      chk({tag, "_w0"}, {64'd0, wa[wbase], wd[wbase]}, {64'd0, 32'h0, 32'h2408_0005});
      chk({tag, "_w1"}, {64'd0, wa[wbase+1], wd[wbase+1]}, {64'd0, 32'h4, 32'h0000_0008});
    end
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 8'hAA, 1'b1, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 8'h02, 1'b1, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 8'h24, 1'b1, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 8'h08, 1'b1, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 8'h05, 1'b1, 1'b1, 32'h0, 32'h2408_0005, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h2408_0005, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h2408_0005, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h2408_0005, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 8'h08, 1'b1, 1'b1, 32'h4, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 8'h24, 1'b1, 1'b0, 32'h4, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 8'h08, 1'b1, 1'b0, 32'h4, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(1'b1, 8'h00, 1'b1, 1'b0, 32'h4, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, 8'h0D, 1'b0, 1'b0, 32'h4, 32'h0000_0008, 1'b1, 1'b0, 1'b1);
    tbl[17] = mk(1'b1, 8'h55, 1'b0, 1'b0, 32'h4, 32'h0000_0008, 1'b1, 1'b0, 1'b1);

    // Reset state while rst_n is held low.
    repeat (2) @(negedge clk);
    chk("reset_state", outs(), 128'd0);

    // Nominal frame, one row per clock; row 0 offers a byte before byte_ready is up.
    wbase = nw;
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      byte_valid = tbl[i].v;
      byte_data = tbl[i].d;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("nominal_row%0d", i), outs(),
          {59'd0, tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].done, tbl[i].err, tbl[i].cpu});
    end
    byte_valid = 1'b0;
    chk_nominal_writes("nominal");

    // Zero-word image.
    do_reset();
    send_word(32'h0, 1'b0);
    send_word(32'h0, 1'b0);
    byte_valid = 1'b0;
    chk("zero_status", {125'd0, load_done, cpu_rst_n, byte_ready}, {125'd0, 3'b110});
    chk("zero_nwrites", 128'(nw - wbase), 128'd0);

    // Bad checksum; later bytes must be ignored.
    do_reset();
    send_nominal(1'b0, 32'h2408_000E);
    chk("badcs_status", {124'd0, load_error, load_done, cpu_rst_n, byte_ready}, {124'd0, 4'b1000});
    chk_nominal_writes("badcs");
    byte_valid = 1'b1;
    byte_data = 8'h00;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    chk("badcs_after", {124'd0, load_error, load_done, cpu_rst_n, byte_ready}, {124'd0, 4'b1000});
    chk("badcs_after_nwrites", 128'(nw - wbase), 128'd2);

    // Oversize header.
    do_reset();
    send_word(32'h0000_0101, 1'b0);
    byte_valid = 1'b0;
    chk("oversize_status", {124'd0, load_error, load_done, cpu_rst_n, byte_ready}, {124'd0, 4'b1000});
    chk("oversize_nwrites", 128'(nw - wbase), 128'd0);

    // Exactly MAX_WORDS is accepted.
    do_reset();
    send_word(32'h0000_0100, 1'b0);
    byte_valid = 1'b0;
    chk("max_hdr_status", {126'd0, load_error, byte_ready}, {126'd0, 2'b01});

    // Nominal frame with random gaps and garbage data.
    do_reset();
    send_nominal(1'b1, 32'h2408_000D);
    chk("gaps_status", {124'd0, load_error, load_done, cpu_rst_n, byte_ready}, {124'd0, 4'b0110});
    chk_nominal_writes("gaps");

    // Reset in the middle of the data phase, then a clean reload.
    do_reset();
    send_word(32'h0000_0002, 1'b0);
    send_word(32'h2408_0005, 1'b0);
    send(8'h00);
    send(8'h00);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", outs(), 128'd0);
    repeat (2) @(negedge clk);
    wbase = nw;
    rst_n = 1'b1;
    send_nominal(1'b0, 32'h2408_000D);
    chk("midreset_status", {124'd0, load_error, load_done, cpu_rst_n, byte_ready}, {124'd0, 4'b0110});
    chk_nominal_writes("midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the processor's instruction memory before the core runs. It is the writer side of the instruction-memory read path. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words to sequential instruction-memory addresses and holds the processor in reset until a complete, checksum-verified image has been loaded.

## Interface
Parameters:
- ADDR_BASE, 32'd0: byte address of the first word written.
- MAX_WORDS, 256: largest word count accepted in the header.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- byte_valid  input  1  source presents a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader can accept a byte; a byte transfers on a clock edge where byte_valid && byte_ready.
- imem_write_en  output  1  one-cycle instruction-memory write strobe.
- imem_write_addr  output  32  word-aligned byte address for the write.
- imem_write_data  output  32  word to write.
- cpu_rst_n  output  1  active-low reset to the processor; low until the load succeeds.
- load_done  output  1  image loaded and verified (sticky).
- load_error  output  1  frame rejected (sticky).

## Operation
- Frame format: 4-byte word count N (big-endian), then N data words of 4 bytes each (big-endian, first byte lands in [31:24]), then a 4-byte checksum (big-endian).
- Checksum = 32-bit wrapping sum of all N data words. A zero-word image has checksum 0.
- States:
  - HDR: collect 4 count bytes.
  - DATA: collect words.
  - CSUM: collect 4 checksum bytes.
  - DONE and ERROR: terminal.
- Transitions out of HDR, after the 4th header byte:
  - N > MAX_WORDS goes to ERROR.
  - N == 0 goes to CSUM.
  - Otherwise go to DATA.
- In DATA, a 2-bit byte counter shifts bytes into a word register. On the 4th byte:
  - issue the write;
  - add the word to the running sum (mod 2^32);
  - increment the word index.
  - After word N-1 the FSM goes to CSUM.
- Transitions out of CSUM, after the 4th byte:
  - received value == running sum goes to DONE;
  - otherwise go to ERROR.
- Write address = ADDR_BASE + 4*index, with index counting 0..N-1. Address arithmetic is 32-bit and wraps silently.
- DONE: byte_ready=0, load_done=1, cpu_rst_n=1. Any further bytes are not accepted.
- ERROR: byte_ready=0, load_error=1, cpu_rst_n stays 0. Only rst_n exits DONE or ERROR.
- byte_valid with byte_ready low has no effect. byte_data is ignored when byte_valid is low. Gaps in byte_valid are permitted anywhere in the frame.

## Timing
- Reset values (held while rst_n low, applied asynchronously):
  - byte_ready=0, imem_write_en=0, imem_write_addr=0, imem_write_data=0;
  - cpu_rst_n=0, load_done=0, load_error=0;
  - state=HDR, counters and sum cleared.
- byte_ready rises at the first rising edge after rst_n deasserts. It then stays 1 through HDR, DATA and CSUM.
- Maximum throughput is one byte per cycle; the loader never stalls the source mid-frame.
- Write latency: imem_write_en is registered. It is high for exactly the one cycle following the edge on which the 4th byte of a word is accepted. addr/data are valid in that same cycle and hold their values until the next write.
- Entry into DONE or ERROR occurs on the edge that accepts the final relevant byte (4th checksum byte, or 4th header byte when N > MAX_WORDS). byte_ready is low and the status outputs are updated in the following cycle.
- cpu_rst_n rises in the same cycle as load_done. It is registered and glitch-free.
- rst_n asserted mid-frame aborts immediately: all outputs return to reset values and partial words are discarded. The next frame starts from the header.
- With minimum-gap streaming, total load time is 4+4N+4 cycles of accepted bytes plus 1 cycle to DONE.

## Test plan
- Nominal load: stream 00 00 00 02, 24 08 00 05, 00 00 00 08, checksum 24 08 00 0D, with byte_valid held high. Required response:
  - imem writes (0x0, 0x24080005) then (0x4, 0x00000008), each a one-cycle strobe;
  - load_done=1 and cpu_rst_n=1 one cycle after the last byte.
- Zero-word image: stream 00 00 00 00 00 00 00 00 -> no imem writes; load_done=1.
- Bad checksum: the nominal frame with checksum 24 08 00 0E -> both writes occur; load_error=1, cpu_rst_n=0, byte_ready=0; the next bytes are not accepted.
- Oversize header: count 00 00 01 01 with MAX_WORDS=256 -> ERROR after the 4th byte; no writes; load_error=1.
- Backpressure-free gaps: the nominal frame with random 0-3 cycle byte_valid gaps and garbage on byte_data during gaps -> writes and DONE identical to the nominal case.
- Reset mid-load: assert rst_n after 6 data bytes, then release and send the full nominal frame -> all outputs return to reset values during reset; after release, exactly 2 writes at 0x0/0x4, then load_done=1.
